vga_timing_recovery: RTL and testbench

Sink-side counterpart of the VGA timing generator. It watches an incoming active-low hsync/vsync pair, recovers pixel coordinates with a flywheel counter, and regenerates the data-enable signal. It checks every sync edge against the expected timing and reports lock, errors and the measured line/frame periods. It sits in front of capture, overlay and monitor logic that receive a sync stream rather than the generator's counters.

---
 rtl/vga_timing_recovery.sv | 177 +++++++++++++++++
 tb/tb_vga_timing_recovery.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_recovery.sv
// Recovers VGA pixel coordinates from an incoming active-low hsync/vsync pair with a flywheel
// counter, qualifies every sync edge, and reports lock, timing errors and measured periods.
module vga_timing_recovery #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int LOCK_LINES = 4,
  parameter int MISS_MAX   = 3
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [9:0] h_period,
  output logic [9:0] v_period
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] HT_LAST = 10'(HT - 1);
  localparam logic [9:0] VT_LAST = 10'(VT - 1);
  localparam logic [9:0] HS_X    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] VS_Y    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] SAT     = 10'h3FF;
  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [GW-1:0] GOOD_LIM = GW'(LOCK_LINES);
  localparam logic [MW:0]   MISS_LIM = (MW + 1)'(MISS_MAX);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t        state, state_nxt;
  logic          hs_d, vs_d;
  logic          hs_fall, vs_fall;
  logic [9:0]    fly_x, fly_y;
  logic [9:0]    x_nxt, y_nxt;
  logic          h_at, v_at, tracking;
  logic          h_good, h_bad, v_bad;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [MW-1:0] miss_cnt, miss_nxt;
  logic [MW:0]   miss_sum;
  logic [9:0]    h_meas, h_meas_nxt, v_meas, v_meas_nxt;
  logic [9:0]    h_period_nxt, v_period_nxt;
  logic          h_seen, v_seen;
  logic          de_nxt;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      x        <= '0;
      y        <= '0;
      de       <= 1'b0;
      locked   <= 1'b0;
      h_err    <= 1'b0;
      v_err    <= 1'b0;
      good_cnt <= '0;
      miss_cnt <= '0;
      h_meas   <= '0;
      v_meas   <= '0;
      h_seen   <= 1'b0;
      v_seen   <= 1'b0;
      h_period <= '0;
      v_period <= '0;
    end else begin
      state    <= state_nxt;
      hs_d     <= hsync_in;
      vs_d     <= vsync_in;
      x        <= x_nxt;
      y        <= y_nxt;
      de       <= de_nxt;
      locked   <= (state_nxt == LOCKED);
      h_err    <= h_bad;
      v_err    <= v_bad;
      good_cnt <= good_nxt;
      miss_cnt <= miss_nxt;
      h_meas   <= h_meas_nxt;
      v_meas   <= v_meas_nxt;
      h_seen   <= h_seen | hs_fall;
      v_seen   <= v_seen | vs_fall;
      h_period <= h_period_nxt;
      v_period <= v_period_nxt;
    end
  end

  always_comb begin
    hs_fall = hs_d & ~hsync_in;
    vs_fall = vs_d & ~vsync_in;

    fly_x = (x == HT_LAST) ? 10'd0 : x + 10'd1;
    fly_y = y;
    if (fly_x == 10'd0) fly_y = (y == VT_LAST) ? 10'd0 : y + 10'd1;

    h_at     = (fly_x == HS_X);
    v_at     = (fly_x == 10'd0) && (fly_y == VS_Y);
    tracking = (state != SEARCH);

    // A missing hsync is only an error once tracking; a missing vsync only once locked.
    h_good = hs_fall && h_at;
    h_bad  = tracking && (hs_fall != h_at);
    v_bad  = (tracking && vs_fall && !v_at) || (state == LOCKED && !vs_fall && v_at);

    x_nxt = fly_x;
    y_nxt = fly_y;
    if (tracking && vs_fall && !v_at) begin
      x_nxt = 10'd0;
      y_nxt = VS_Y;
    end
    // hsync owns x, so it wins when both realignments fire together.
    if (hs_fall && !h_at) x_nxt = HS_X;

    state_nxt = state;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    miss_sum  = (h_good ? '0 : {1'b0, miss_cnt}) + {{MW{1'b0}}, h_bad} + {{MW{1'b0}}, v_bad};
    case (state)
      SEARCH: begin
        if (hs_fall) begin
          state_nxt = ALIGN;
          good_nxt  = '0;
          miss_nxt  = '0;
        end
      end
      ALIGN: begin
        if (h_good) begin
          if (good_cnt != GOOD_LIM) good_nxt = good_cnt + GW'(1);
        end else if (h_bad) begin
          good_nxt = '0;
        end
        if (vs_fall && good_cnt >= GOOD_LIM && fly_x == 10'd0) begin
          state_nxt = LOCKED;
          miss_nxt  = '0;
        end
      end
      LOCKED: begin
        if (miss_sum >= MISS_LIM) begin
          state_nxt = SEARCH;
          miss_nxt  = '0;
          good_nxt  = '0;
        end else begin
          miss_nxt = miss_sum[MW-1:0];
        end
      end
      default: state_nxt = SEARCH;
    endcase

    de_nxt = (state_nxt == LOCKED) && (x_nxt < H_VIS) && (y_nxt < V_VIS);

    // h_meas holds clocks elapsed since the last hsync edge, so it is the period at the next one.
    h_meas_nxt   = hs_fall ? 10'd1 : ((h_meas == SAT) ? h_meas : h_meas + 10'd1);
    h_period_nxt = (hs_fall && h_seen) ? h_meas : h_period;

    v_meas_nxt   = v_meas;
    v_period_nxt = v_period;
    if (vs_fall) begin
      v_meas_nxt = 10'd0;
      if (v_seen) v_period_nxt = (v_meas == SAT || !hs_fall) ? v_meas : v_meas + 10'd1;
    end else if (hs_fall && v_meas != SAT) begin
      v_meas_nxt = v_meas + 10'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Directed bench for vga_timing_recovery: a small-raster sync generator feeds the DUT and
// hand-derived coordinates, pulses and periods are checked with immediate assertions.
module tb_vga_timing_recovery;

  localparam int HV = 40, HF = 4, HS = 8, HB = 8;
  localparam int VV = 20, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;   // 60
  localparam int VT = VV + VF + VS + VB;   // 30
  localparam int HS_X = HV + HF;           // 44
  localparam int VS_Y = VV + VF;           // 23
  localparam int FRAME = HT * VT;

  logic       clk_25mhz = 1'b0;
  logic       reset;
  logic       hsync_in, vsync_in;
  logic [9:0] x, y, h_period, v_period;
  logic       de, locked, h_err, v_err;

  int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
  int gen_h, gen_v;
  int sup_lo = 1, sup_hi = 0;
  int shift_line = -1;
  bit hs_off = 1'b0;

  vga_timing_recovery #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_LINES(4), .MISS_MAX(3)
  ) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .de(de), .locked(locked), .h_err(h_err), .v_err(v_err),
    .h_period(h_period), .v_period(v_period)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the generator, drive its syncs, then sample one clock later.
  task automatic cyc();
    int sh;
    bit hs_low;
    if (gen_h == HT - 1) begin
      gen_h = 0;
      gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
    end else begin
      gen_h++;
    end
    sh = (gen_v == shift_line) ? 5 : 0;
    hs_low = (gen_h >= HS_X + sh) && (gen_h < HS_X + sh + HS);
    if (hs_off || (gen_v >= sup_lo && gen_v <= sup_hi)) hs_low = 1'b0;
    hsync_in = ~hs_low;
    vsync_in = ~((gen_v >= VS_Y) && (gen_v < VS_Y + VS));
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(gen_h == h && gen_v == v) && n < 2 * FRAME) begin
      cyc();
      n++;
    end
  endtask

  task automatic start_from_reset();
    reset = 1'b1;
    gen_h = HT - 1;
    gen_v = VT - 1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge clk_25mhz);
    #1;
  endtask

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, errs, mism, de_hi, hp0, hp1, herr_n, herr_pos, lk_bad, lk2, lk3, lock_pos;
    int herr5, x5, hp5, hp6;

    start_from_reset();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_de", de, 0);
    check("rst_locked", locked, 0);
    check("rst_h_err", h_err, 0);
    check("rst_v_err", v_err, 0);
    check("rst_h_period", h_period, 0);
    check("rst_v_period", v_period, 0);
    reset = 1'b0;

    // Acquire lock from a clean generator stream.
    n = 0; errs = 0; hp0 = -1; hp1 = -1;
    while (locked !== 1'b1 && n < 3 * FRAME) begin
      cyc();
      n++;
      if (h_err !== 1'b0 || v_err !== 1'b0) errs++;
      if (gen_h == HS_X && gen_v == 0) hp0 = h_period;
      if (gen_h == HS_X && gen_v == 1) hp1 = h_period;
    end
    check("lock_acquired", locked, 1);
    check("lock_position", gen_v * HT + gen_h, VS_Y * HT);
    check("no_err_before_lock", errs, 0);
    check("h_period_first_edge", hp0, 0);
    check("h_period_second_edge", hp1, HT);
    check("v_period_first_edge", v_period, 0);

    mism = 0; de_hi = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      if (x !== gen_h || y !== gen_v || de !== (gen_h < HV && gen_v < VV) ||
          locked !== 1'b1 || h_err !== 1'b0 || v_err !== 1'b0) mism++;
      if (de === 1'b1) de_hi++;
    end
    check("track_2frames_mismatch", mism, 0);
    check("de_count_2frames", de_hi, 2 * HV * VV);
    check("h_period_nominal", h_period, HT);
    check("v_period_nominal", v_period, VT);

    // One line without hsync: a single missed-edge error, no realign.
    sup_lo = 5; sup_hi = 5;
    run_to(0, 5);
    herr_n = 0; herr_pos = -1; mism = 0; lk_bad = 0;
    for (int i = 0; i < HT + HS_X + 1; i++) begin
      cyc();
      if (h_err === 1'b1) begin herr_n++; herr_pos = gen_v * HT + gen_h; end
      if (x !== gen_h) mism++;
      if (locked !== 1'b1) lk_bad++;
    end
    sup_lo = 1; sup_hi = 0;
    check("miss1_h_err_count", herr_n, 1);
    check("miss1_h_err_pos", herr_pos, 5 * HT + HS_X);
    check("miss1_x_flywheel", mism, 0);
    check("miss1_locked_held", lk_bad, 0);

    // Three lines without hsync drop lock on the third error.
    sup_lo = 8; sup_hi = 10;
    run_to(0, 8);
    herr_n = 0; lk2 = -1; lk3 = -1;
    for (int i = 0; i < 2 * HT + HS_X + 1; i++) begin
      cyc();
      if (h_err === 1'b1) herr_n++;
      if (gen_h == HS_X && gen_v == 9) lk2 = locked;
      if (gen_h == HS_X && gen_v == 10) lk3 = locked;
    end
    sup_lo = 1; sup_hi = 0;
    check("miss3_h_err_count", herr_n, 3);
    check("miss3_locked_after_2", lk2, 1);
    check("miss3_locked_after_3", lk3, 0);
    n = 0; de_hi = 0;
    while (locked !== 1'b1 && n < 2 * FRAME) begin
      cyc();
      n++;
      if (de !== 1'b0) de_hi++;
    end
    check("relock_acquired", locked, 1);
    check("relock_position", gen_v * HT + gen_h, VS_Y * HT);
    check("de_low_while_unlocked", de_hi, 0);

    // hsync 5 clocks late on line 3.
    shift_line = 3;
    run_to(0, 3);
    herr5 = -1; x5 = -1; hp5 = -1; hp6 = -1;
    for (int i = 0; i < 2 * HT; i++) begin
      cyc();
      if (gen_h == HS_X + 5 && gen_v == 3) begin herr5 = h_err; x5 = x; hp5 = h_period; end
      if (gen_h == HS_X && gen_v == 4) hp6 = h_period;
    end
    shift_line = -1;
    check("late_h_err", herr5, 1);
    check("late_x_realign", x5, HS_X);
    check("late_h_period", hp5, HT + 5);
    check("after_late_h_period", hp6, HT - 5);

    // Asynchronous reset in the middle of a visible line.
    run_to(0, VS_Y);
    run_to(30, 10);
    check("pre_rst_locked", locked, 1);
    check("pre_rst_de", de, 1);
    check("pre_rst_x", x, 30);
    check("pre_rst_y", y, 10);
    #5;
    reset = 1'b1;
    #1;
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_de", de, 0);
    check("midrst_locked", locked, 0);
    check("midrst_h_period", h_period, 0);
    check("midrst_v_period", v_period, 0);

    // h_period saturates when hsync disappears for more than 1023 clocks.
    start_from_reset();
    reset = 1'b0;
    run_to(HS_X, 0);
    check("sat_first_edge", h_period, 0);
    hs_off = 1'b1;
    repeat (1100) cyc();
    n = 0;
    while (gen_h != 0 && n < HT) begin cyc(); n++; end
    hs_off = 1'b0;
    n = 0;
    while (gen_h != HS_X && n < HT) begin cyc(); n++; end
    check("h_period_saturate", h_period, 1023);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
